if_stage_prefetch: RTL

- Parametrised next-generation instruction fetch stage that decouples fetch from decode.
- Keeps up to MAX_OUTSTANDING pipelined read requests in flight on a split request/response memory channel.
- Buffers returned instructions, with their PCs, in a FETCH_DEPTH-entry FIFO.
- Sits between the PC/redirect source and the ID stage. Flush/redirect discards buffered entries and silently drops responses still in flight.

---
 rtl/if_stage_prefetch_if.sv | 27 ++
 rtl/if_stage_prefetch.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_stage_prefetch_if.sv
// Split request/response read channel between the fetch stage and instruction memory.
// Responses return in request order and are always accepted by the master.
interface if_stage_prefetch_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/if_stage_prefetch.sv
// Prefetching instruction fetch stage: pipelined reads on a split channel, fetched words buffered
// with their PCs ahead of decode. Define IFETCH_PERF_CNT_EN to add fetched/dropped counters.
module if_stage_prefetch #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              FETCH_DEPTH     = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic [XLEN-1:0]     i_redirect_pc,
    if_stage_prefetch_if.master mem,
    output logic                o_if_valid,
    output logic [XLEN-1:0]     o_if_pc,
    output logic [XLEN-1:0]     o_if_instr
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]         o_perf_fetched,
    output logic [31:0]         o_perf_dropped
`endif
);
    localparam int FW   = $clog2(FETCH_DEPTH);
    localparam int CNTW = $clog2(FETCH_DEPTH + 1);
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_nxt;
    logic [CW-1:0]   drop_cnt;

    fetch_entry_t    fifo_mem [FETCH_DEPTH];
    logic [FW-1:0]   fifo_rd;
    logic [FW-1:0]   fifo_wr;
    logic [CNTW-1:0] fifo_cnt;

    logic [XLEN-1:0] tag_q [MAX_OUTSTANDING];
    logic [TW-1:0]   tag_rd;
    logic [TW-1:0]   tag_wr;
    logic [TW-1:0]   tag_rd_nxt;
    logic [TW-1:0]   tag_wr_nxt;

    logic [31:0]     credit_used;
    logic            req_fire;
    logic            rsp_ok;
    logic            rsp_drop;
    logic            fifo_push;
    logic            fifo_pop;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    // Credits cover buffered entries plus live (non-dropped) requests, so the FIFO can never overflow.
    // Gated by rst_n so the request channel is quiet while held in reset.
    assign credit_used   = 32'(fifo_cnt) + 32'(inflight) - 32'(drop_cnt);
    assign mem.req_valid = rst_n && !i_flush
                        && (32'(inflight) < 32'(MAX_OUTSTANDING))
                        && (credit_used < 32'(FETCH_DEPTH));
    assign mem.req_addr  = pc_q;

    assign req_fire  = mem.req_valid && mem.req_ready;
    assign rsp_ok    = mem.rsp_valid && (inflight != '0);
    assign rsp_drop  = rsp_ok && (i_flush || (drop_cnt != '0));
    assign fifo_push = rsp_ok && !rsp_drop;
    assign fifo_pop  = o_if_valid && !i_stall && !i_flush;

    assign o_if_valid = (fifo_cnt != '0);
    assign o_if_pc    = o_if_valid ? fifo_mem[fifo_rd].pc    : '0;
    assign o_if_instr = o_if_valid ? fifo_mem[fifo_rd].instr : '0;

    assign tag_rd_nxt = (tag_rd == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd + TW'(1);
    assign tag_wr_nxt = (tag_wr == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr + TW'(1);

    always_comb begin
        inflight_nxt = inflight;
        if (req_fire) inflight_nxt = inflight_nxt + CW'(1);
        if (rsp_ok)   inflight_nxt = inflight_nxt - CW'(1);
    end

    // Storage arrays carry no reset; validity comes from the pointers and counters.
    always_ff @(posedge clk) begin
        if (req_fire) tag_q[tag_wr] <= pc_q;
        if (fifo_push) begin
            fifo_mem[fifo_wr].pc    <= tag_q[tag_rd];
            fifo_mem[fifo_wr].instr <= mem.rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            fifo_cnt <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (req_fire) begin
                pc_q   <= pc_q + XLEN'(4);
                tag_wr <= tag_wr_nxt;
            end
            if (rsp_ok) tag_rd <= tag_rd_nxt;

            if (i_flush) begin
                // Tags stay queued: every request still in flight is now owed a drop.
                pc_q     <= {i_redirect_pc[XLEN-1:2], 2'b00};
                drop_cnt <= inflight_nxt;
                fifo_rd  <= '0;
                fifo_wr  <= '0;
                fifo_cnt <= '0;
            end else begin
                if (rsp_drop)  drop_cnt <= drop_cnt - CW'(1);
                if (fifo_push) fifo_wr  <= fifo_wr + FW'(1);
                if (fifo_pop)  fifo_rd  <= fifo_rd + FW'(1);
                case ({fifo_push, fifo_pop})
                    2'b10:   fifo_cnt <= fifo_cnt + CNTW'(1);
                    2'b01:   fifo_cnt <= fifo_cnt - CNTW'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem.rsp_valid) assert (inflight != '0);
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [32:0] fetched_sum;
    logic [32:0] dropped_sum;

    assign fetched_sum = {1'b0, o_perf_fetched} + 33'(fifo_push);
    assign dropped_sum = {1'b0, o_perf_dropped} + 33'(rsp_drop)
                       + (i_flush ? 33'(fifo_cnt) : 33'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_perf_fetched <= '0;
            o_perf_dropped <= '0;
        end else begin
            o_perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            o_perf_dropped <= dropped_sum[32] ? '1 : dropped_sum[31:0];
        end
    end
`endif

endmodule
